// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding and line levels.
// No logic, no latency, no flow control.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_t;

   localparam logic UART_IDLE_LEVEL  = 1'b1;
   localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time divider: bit_end pulses on the last clk_uart cycle of every CLKS_PER_BIT period.
// Latency: restart aligns the next bit time to the following cycle; no backpressure.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk_uart,
   input  logic clrn,
   input  logic restart,
   output logic bit_end
);

   localparam int            CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   assign bit_end = (cnt == LAST);

   always_ff @(posedge clk_uart or negedge clrn) begin
      if (!clrn) begin
         cnt <= '0;
      end else if (restart || bit_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start, DATA_BITS LSB first, parity when UART_TX_PARITY_EN, STOP_BITS stops.
// Latency: start bit on txd one cycle after accept; tx_ready low for the whole frame, re-opens in the tx_done cycle.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk_uart,
   input  logic                 clrn,
   input  logic [DATA_BITS-1:0] d_in,
   input  logic                 tx_send,
   output logic                 tx_ready,
   output logic                 txd,
   output logic                 sending,
   output logic                 tx_done
);

   localparam int            MAXB      = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
   localparam int            BW        = $clog2(MAXB);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   // Out-of-range configurations stop elaboration rather than build a malformed frame.
   if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
       STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_cfg_check
      $error("uart_tx_frame: parameter out of range");
   end

   uart_tx_state_t       state, state_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;
   logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
   logic                 bit_end, accept, last_stop, baud_restart, txd_nxt;
`ifdef UART_TX_PARITY_EN
   localparam logic PAR_ODD = (PARITY_ODD != 0);
   logic par_bit, par_nxt;
`endif

   assign last_stop    = (state == STOP) && bit_end && (bit_cnt == LAST_STOP);
   assign tx_done      = last_stop;
   assign tx_ready     = (state == IDLE) || last_stop;
   assign accept       = tx_send && tx_ready;
   assign baud_restart = (state == IDLE) || accept;

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk_uart(clk_uart),
      .clrn    (clrn),
      .restart (baud_restart),
      .bit_end (bit_end)
   );

   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
`ifdef UART_TX_PARITY_EN
      par_nxt     = par_bit;
`endif
      case (state)
         START: if (bit_end) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
         end
         DATA: if (bit_end) begin
            if (bit_cnt == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
               state_nxt = PARITY;
`else
               state_nxt = STOP;
`endif
               bit_cnt_nxt = '0;
            end else begin
               shreg_nxt   = shreg >> 1;
               bit_cnt_nxt = bit_cnt + BW'(1);
            end
         end
         PARITY: if (bit_end) begin
            state_nxt   = STOP;
            bit_cnt_nxt = '0;
         end
         STOP: if (bit_end) begin
            if (bit_cnt == LAST_STOP) begin
               state_nxt   = IDLE;
               bit_cnt_nxt = '0;
            end else begin
               bit_cnt_nxt = bit_cnt + BW'(1);
            end
         end
         default: ;
      endcase
      // Accept also fires in the last stop cycle, chaining frames with no idle gap.
      if (accept) begin
         state_nxt   = START;
         bit_cnt_nxt = '0;
         shreg_nxt   = d_in;
`ifdef UART_TX_PARITY_EN
         par_nxt     = (^d_in) ^ PAR_ODD;
`endif
      end
      case (state_nxt)
         START:   txd_nxt = UART_START_LEVEL;
         DATA:    txd_nxt = shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  txd_nxt = par_nxt;
`endif
         default: txd_nxt = UART_IDLE_LEVEL;
      endcase
   end

   always_ff @(posedge clk_uart or negedge clrn) begin
      if (!clrn) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         txd     <= UART_IDLE_LEVEL;
         sending <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_bit <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         shreg   <= shreg_nxt;
         bit_cnt <= bit_cnt_nxt;
         txd     <= txd_nxt;
         sending <= (state_nxt != IDLE);
`ifdef UART_TX_PARITY_EN
         par_bit <= par_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: three configurations, directed words, cycle-exact frame monitor.
`timescale 1ns/1ps
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
   localparam int PEN = 1;
`else
   localparam int PEN = 0;
`endif

   typedef struct {
      int          inst;
      logic [15:0] bits;
      int          nbits;
      int          cpb;
      int          start_cyc;
      bit          abort;
   } exp_t;

   logic clk_uart = 1'b0;
   logic clrn     = 1'b0;
   always #5 clk_uart = ~clk_uart;

   int cyc = 0;
   always @(posedge clk_uart) cyc <= cyc + 1;

   logic [7:0] d_a, d_b;
   logic [4:0] d_c;
   logic send_a, send_b, send_c;
   logic ready_a, ready_b, ready_c;
   logic txd_a, txd_b, txd_c;
   logic sending_a, sending_b, sending_c;
   logic done_a, done_b, done_c;

   uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_a (
      .clk_uart(clk_uart), .clrn(clrn), .d_in(d_a), .tx_send(send_a),
      .tx_ready(ready_a), .txd(txd_a), .sending(sending_a), .tx_done(done_a));
   uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1)) u_b (
      .clk_uart(clk_uart), .clrn(clrn), .d_in(d_b), .tx_send(send_b),
      .tx_ready(ready_b), .txd(txd_b), .sending(sending_b), .tx_done(done_b));
   uart_tx_frame #(.CLKS_PER_BIT(2), .DATA_BITS(5), .STOP_BITS(1), .PARITY_ODD(0)) u_c (
      .clk_uart(clk_uart), .clrn(clrn), .d_in(d_c), .tx_send(send_c),
      .tx_ready(ready_c), .txd(txd_c), .sending(sending_c), .tx_done(done_c));

   exp_t exp_q[$];
   int   n_pass = 0;
   int   n_chk  = 0;
   bit   mon_busy = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, got, want);
   endtask

   function automatic logic [2:0] mon_sig(input int i);
      case (i)
         0:       return {txd_a, done_a, sending_a};
         1:       return {txd_b, done_b, sending_b};
         default: return {txd_c, done_c, sending_c};
      endcase
   endfunction

   function automatic int frame_cycles(input int inst);
      case (inst)
         0:       return (1 + 8 + PEN + 1) * 4;
         1:       return (1 + 8 + PEN + 2) * 4;
         default: return (1 + 5 + PEN + 1) * 2;
      endcase
   endfunction

   // Builds the expected line levels one entry per bit time; stop bits stay at the preset 1s.
   task automatic expect_frame(input int inst, input logic [8:0] data, input logic par,
                               input int start_cyc, input bit abort);
      exp_t e;
      int   db, sb;
      db = (inst == 2) ? 5 : 8;
      sb = (inst == 1) ? 2 : 1;
      e.inst      = inst;
      e.cpb       = (inst == 2) ? 2 : 4;
      e.bits      = '1;
      e.bits[0]   = 1'b0;
      for (int k = 0; k < db; k++) e.bits[1 + k] = data[k];
      if (PEN == 1) e.bits[1 + db] = par;
      e.nbits     = 1 + db + PEN + sb;
      e.start_cyc = start_cyc;
      e.abort     = abort;
      exp_q.push_back(e);
   endtask

   task automatic drive(input int inst, input logic [8:0] data, input logic req);
      case (inst)
         0:       begin d_a = data[7:0]; send_a = req; end
         1:       begin d_b = data[7:0]; send_b = req; end
         default: begin d_c = data[4:0]; send_c = req; end
      endcase
   endtask

   task automatic send(input int inst, input logic [8:0] data, input logic par);
      @(posedge clk_uart); #1;
      expect_frame(inst, data, par, cyc + 1, 1'b0);
      drive(inst, data, 1'b1);
      @(posedge clk_uart); #1;
      drive(inst, ~data, 1'b0);
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || mon_busy || sending_a || sending_b || sending_c) && t < 3000) begin
         @(negedge clk_uart);
         t++;
      end
      if (t >= 3000) begin
         n_chk++;
         $display("FAIL drain_timeout: %0d frames still pending after %0d cycles, required 0", exp_q.size(), t);
      end
      repeat (3) @(negedge clk_uart);
   endtask

   initial begin : monitor
      exp_t        e;
      int          inst, len, errs_txd, errs_send, done_at, done_cnt;
      bit          aborted;
      logic [2:0]  s;
      logic [15:0] act, want;
      forever begin
         @(negedge clk_uart);
         inst = -1;
         if (clrn) begin
            for (int i = 2; i >= 0; i--) begin
               s = mon_sig(i);
               if (s[2] == 1'b0) inst = i;
            end
         end
         if (inst >= 0) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_frame: got a frame on instance %0d at cycle %0d, required none", inst, cyc);
               for (int t = 0; t < 200; t++) begin
                  s = mon_sig(inst);
                  if (!s[0]) break;
                  @(negedge clk_uart);
               end
            end else begin
               e = exp_q.pop_front();
               mon_busy = 1'b1;
               check("frame_instance", inst, e.inst);
               check("start_cycle", cyc, e.start_cyc);
               len = e.nbits * e.cpb;
               errs_txd = 0; errs_send = 0; done_at = -1; done_cnt = 0;
               aborted = 1'b0; act = '0;
               for (int i = 0; i < len; i++) begin
                  if (i > 0) @(negedge clk_uart);
                  if (!clrn) begin
                     aborted = 1'b1;
                     break;
                  end
                  s = mon_sig(inst);
                  if (i % e.cpb == 0) act[i / e.cpb] = s[2];
                  if (s[2] !== e.bits[i / e.cpb]) errs_txd++;
                  if (s[0] !== 1'b1) errs_send++;
                  if (s[1] === 1'b1) begin
                     done_cnt++;
                     if (done_at < 0) done_at = i;
                  end
               end
               check("frame_aborted", aborted, e.abort);
               check("txd_cycle_errs", errs_txd, 0);
               check("sending_errs", errs_send, 0);
               if (!aborted) begin
                  want = e.bits & 16'((32'd1 << e.nbits) - 1);
                  check("txd_bits", act, want);
                  check("done_cycle", done_at, len - 1);
                  check("done_count", done_cnt, 1);
               end
               mon_busy = 1'b0;
            end
         end
      end
   end

   initial begin : stim
      int s1, la, bad_txd, bad_rdy, bad_snd, bad_done;
      d_a = '0; d_b = '0; d_c = '0;
      send_a = 1'b0; send_b = 1'b0; send_c = 1'b0;

      // Reset and idle
      repeat (5) @(posedge clk_uart);
      #1;
      check("rst_txd", {txd_a, txd_b, txd_c}, 3'b111);
      check("rst_ready", {ready_a, ready_b, ready_c}, 3'b111);
      check("rst_sending", {sending_a, sending_b, sending_c}, 3'b000);
      check("rst_done", {done_a, done_b, done_c}, 3'b000);
      @(negedge clk_uart);
      clrn = 1'b1;
      bad_txd = 0; bad_rdy = 0; bad_snd = 0; bad_done = 0;
      repeat (100) begin
         @(negedge clk_uart);
         if ({txd_a, txd_b, txd_c} !== 3'b111) bad_txd++;
         if ({ready_a, ready_b, ready_c} !== 3'b111) bad_rdy++;
         if ({sending_a, sending_b, sending_c} !== 3'b000) bad_snd++;
         if ({done_a, done_b, done_c} !== 3'b000) bad_done++;
      end
      check("idle_txd_cycles", bad_txd, 0);
      check("idle_ready_cycles", bad_rdy, 0);
      check("idle_sending_cycles", bad_snd, 0);
      check("idle_done_cycles", bad_done, 0);

      // Basic frames; parity column is the hand-computed even/odd bit
      send(0, 9'h0A5, 1'b0);
      wait_drain();
      send(0, 9'h080, 1'b1);
      wait_drain();

      // Parity polarity and two stop bits
      send(0, 9'h007, 1'b1);
      wait_drain();
      send(1, 9'h007, 1'b0);
      wait_drain();

      // Back-to-back with tx_send held; 8'h33 must never reach the line
      la = frame_cycles(0);
      @(posedge clk_uart); #1;
      s1 = cyc + 1;
      expect_frame(0, 9'h011, 1'b0, s1, 1'b0);
      expect_frame(0, 9'h022, 1'b0, s1 + la, 1'b0);
      d_a = 8'h11; send_a = 1'b1;
      @(posedge clk_uart); #1;
      d_a = 8'h22;
      repeat (15) @(posedge clk_uart);
      #1;
      check("busy_ready", ready_a, 1'b0);
      d_a = 8'h33;
      repeat (2) @(posedge clk_uart);
      #1;
      d_a = 8'h22;
      while (cyc < s1 + la) begin
         @(posedge clk_uart); #1;
      end
      send_a = 1'b0; d_a = 8'h44;
      repeat (10) @(posedge clk_uart);
      #1;
      d_a = 8'h33; send_a = 1'b1;
      @(posedge clk_uart); #1;
      send_a = 1'b0;
      wait_drain();

      // Reset during data bit 3 (8'hC3 bit 3 is 0, so the line is low when reset hits)
      @(posedge clk_uart); #1;
      s1 = cyc + 1;
      expect_frame(0, 9'h0C3, 1'b0, s1, 1'b1);
      d_a = 8'hC3; send_a = 1'b1;
      @(posedge clk_uart); #1;
      send_a = 1'b0;
      while (cyc < s1 + 17) begin
         @(posedge clk_uart); #1;
      end
      check("pre_rst_txd", txd_a, 1'b0);
      #2;
      clrn = 1'b0;
      #1;
      check("midrst_txd", txd_a, 1'b1);
      check("midrst_sending", sending_a, 1'b0);
      repeat (3) @(negedge clk_uart);
      clrn = 1'b1;
      repeat (5) @(negedge clk_uart);
      send(0, 9'h05A, 1'b0);
      wait_drain();

      // Narrowest word at the fastest bit rate
      send(2, 9'h01F, 1'b1);
      wait_drain();
      send(2, 9'h00A, 1'b0);
      wait_drain();

      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
